// File: rtl/fft_seq_ctrl_if.sv
// Signal bundle between fft_seq_ctrl (master) and the FFT datapath/host (slave).
// FFT_BITREV_UNLOAD_EN adds the ul_en/ul_addr unload signals.
interface fft_seq_ctrl_if #(
   parameter int LOG2N = 5
);
   logic             start;
   logic             busy;
   logic             ld_en;
   logic [LOG2N-1:0] ld_addr;
   logic             mem_sel;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
   logic [3:0]       stage_num;
   logic             stage_done;
   logic             fft_done;
`ifdef FFT_BITREV_UNLOAD_EN
   logic             ul_en;
   logic [LOG2N-1:0] ul_addr;
`endif

   modport master (
      input  start,
      output busy, ld_en, ld_addr, mem_sel, rd_en, rd_addr_a, rd_addr_b, tw_addr,
      output wr_en, wr_addr_a, wr_addr_b, stage_num, stage_done, fft_done
`ifdef FFT_BITREV_UNLOAD_EN
      , output ul_en, ul_addr
`endif
   );

   modport slave (
      output start,
      input  busy, ld_en, ld_addr, mem_sel, rd_en, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_en, wr_addr_a, wr_addr_b, stage_num, stage_done, fft_done
`ifdef FFT_BITREV_UNLOAD_EN
      , input ul_en, ul_addr
`endif
   );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIF FFT of 2**LOG2N points: load, stages, drain.
// Define FFT_BITREV_UNLOAD_EN to add a bit-reversed UNLOAD phase before DONE.
module fft_seq_ctrl #(
   parameter int LOG2N      = 5,
   parameter int BF_LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   fft_seq_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, UNLOAD, DONE} state_t;

   localparam logic [LOG2N-1:0] DRAIN_LAST = LOG2N'(BF_LATENCY - 1);

   state_t state_q, state_d;
   logic [LOG2N-1:0] cnt_q, cnt_d;
   logic [3:0]       stage_q, stage_d;

   logic [BF_LATENCY-1:0]             wen_dly_q, wen_dly_d;
   logic [BF_LATENCY-1:0][LOG2N-1:0] wa_dly_q, wa_dly_d;
   logic [BF_LATENCY-1:0][LOG2N-1:0] wb_dly_q, wb_dly_d;

   logic [LOG2N-2:0] k, span_m1, k_lo;
   logic [LOG2N-1:0] k_ext, addr_a, rd_a, rd_b, ul_rev;
   logic [3:0]       h;
   logic             rd_en, stage_done, stage_last;

   // Operand addresses: k's bits above h move up one place to open the span bit.
   always_comb begin
      k       = cnt_q[LOG2N-2:0];
      k_ext   = {1'b0, k};
      span_m1 = {(LOG2N-1){1'b1}} >> stage_q;
      k_lo    = k & span_m1;
      h       = 4'(LOG2N - 1) - stage_q;
      addr_a  = ((k_ext >> h) << (h + 4'd1)) | {1'b0, k_lo};
      rd_en   = (state_q == RUN);
      rd_a    = rd_en ? addr_a : '0;
      rd_b    = rd_en ? addr_a + ({1'b0, span_m1} + LOG2N'(1)) : '0;
   end

   always_comb begin
      ul_rev = '0;
      for (int unsigned i = 0; i < LOG2N; i++) begin
         ul_rev[i] = cnt_q[LOG2N-1-i];
      end
   end

   always_comb begin
      stage_last = (stage_q == 4'(LOG2N - 1));
      state_d    = state_q;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      stage_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (cnt_q == '1) begin
               state_d = RUN;
               cnt_d   = '0;
               stage_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (k == '1) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               stage_done = 1'b1;
               cnt_d      = '0;
               if (!stage_last) begin
                  state_d = RUN;
                  stage_d = stage_q + 4'd1;
               end else begin
`ifdef FFT_BITREV_UNLOAD_EN
                  state_d = UNLOAD;
`else
                  state_d = DONE;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef FFT_BITREV_UNLOAD_EN
         UNLOAD: begin
            if (cnt_q == '1) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
      endcase
   end

   // Write side is the read side delayed by the butterfly pipeline depth.
   always_comb begin
      wen_dly_d    = '0;
      wa_dly_d     = '0;
      wb_dly_d     = '0;
      wen_dly_d[0] = rd_en;
      wa_dly_d[0]  = rd_a;
      wb_dly_d[0]  = rd_b;
      for (int unsigned i = 1; i < BF_LATENCY; i++) begin
         wen_dly_d[i] = wen_dly_q[i-1];
         wa_dly_d[i]  = wa_dly_q[i-1];
         wb_dly_d[i]  = wb_dly_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         stage_q   <= '0;
         wen_dly_q <= '0;
         wa_dly_q  <= '0;
         wb_dly_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         wen_dly_q <= wen_dly_d;
         wa_dly_q  <= wa_dly_d;
         wb_dly_q  <= wb_dly_d;
      end
   end

   always_comb begin
      bus.busy       = (state_q != IDLE);
      bus.ld_en      = (state_q == LOAD);
      bus.ld_addr    = (state_q == LOAD) ? cnt_q : '0;
      bus.mem_sel    = (state_q == LOAD);
      bus.rd_en      = rd_en;
      bus.rd_addr_a  = rd_a;
      bus.rd_addr_b  = rd_b;
      bus.tw_addr    = rd_en ? (k_lo << stage_q) : '0;
      bus.wr_en      = wen_dly_q[BF_LATENCY-1];
      bus.wr_addr_a  = wa_dly_q[BF_LATENCY-1];
      bus.wr_addr_b  = wb_dly_q[BF_LATENCY-1];
      bus.stage_num  = stage_q;
      bus.stage_done = stage_done;
      bus.fft_done   = (state_q == DONE);
`ifdef FFT_BITREV_UNLOAD_EN
      bus.ul_en      = (state_q == UNLOAD);
      bus.ul_addr    = (state_q == UNLOAD) ? ul_rev : '0;
`endif
   end
endmodule
